// File: rtl/led_pattern_ctrl.sv
// LED display-mode controller: button events cycle OFF/BLINK/RUN/FILL, a tick divider steps the pattern.
// Optional brightness PWM on the LED bank is enabled by defining LED_PWM_EN.
module led_pattern_ctrl #(
   parameter int unsigned N_LED    = 8,
   parameter int unsigned TICK_DIV = 50_000_000,
   parameter int unsigned PWM_BITS = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ev_valid,
`ifdef LED_PWM_EN
   input  logic [PWM_BITS-1:0] bright,
`endif
   output logic                ev_read,
   output logic [1:0]          mode,
   output logic                step_tick,
   output logic [N_LED-1:0]    led
);

   localparam int unsigned    CNT_W    = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_BLINK = 2'd1,
      MODE_RUN   = 2'd2,
      MODE_FILL  = 2'd3
   } mode_t;

   // Reject configurations the pattern logic cannot represent.
   if (N_LED < 2 || TICK_DIV < 2 || PWM_BITS < 1) begin : g_param_chk
      $error("led_pattern_ctrl: illegal parameter value");
   end

   mode_t             mode_q, mode_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [N_LED-1:0]  pat_q, pat_d;
   logic [N_LED-1:0]  led_q, led_d;
   logic              ev_read_q;
   logic              step_tick_q;
   logic              wrap_c;

   assign wrap_c = (cnt_q == CNT_LAST);

   // An event takes priority over a coincident step: the step is dropped and the entry pattern loads.
   always_comb begin
      mode_d = mode_q;
      pat_d  = pat_q;
      cnt_d  = wrap_c ? '0 : cnt_q + CNT_W'(1);
      if (ev_valid) begin
         cnt_d  = '0;
         mode_d = mode_t'(mode_q + 2'd1);
         case (mode_d)
            MODE_OFF:   pat_d = '0;
            MODE_BLINK: pat_d = '1;
            MODE_RUN:   pat_d = N_LED'(1);
            MODE_FILL:  pat_d = '0;
            default:    pat_d = '0;
         endcase
      end else if (wrap_c) begin
         case (mode_q)
            MODE_OFF:   pat_d = '0;
            MODE_BLINK: pat_d = ~pat_q;
            MODE_RUN:   pat_d = {pat_q[N_LED-2:0], pat_q[N_LED-1]};
            MODE_FILL:  pat_d = (&pat_q) ? '0 : {pat_q[N_LED-2:0], 1'b1};
            default:    pat_d = '0;
         endcase
      end
   end

`ifdef LED_PWM_EN
   logic [PWM_BITS-1:0] pc_q;

   // Free-running PWM phase; deliberately not disturbed by mode changes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pc_q <= '0;
      else       pc_q <= pc_q + PWM_BITS'(1);
   end

   assign led_d = pat_q & {N_LED{pc_q < bright}};
`else
   assign led_d = pat_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q      <= MODE_OFF;
         cnt_q       <= '0;
         pat_q       <= '0;
         led_q       <= '0;
         ev_read_q   <= 1'b0;
         step_tick_q <= 1'b0;
      end else begin
         mode_q      <= mode_d;
         cnt_q       <= cnt_d;
         pat_q       <= pat_d;
         led_q       <= led_d;
         ev_read_q   <= ev_valid;
         step_tick_q <= wrap_c;
      end
   end

   assign mode      = mode_q;
   assign led       = led_q;
   assign ev_read   = ev_read_q;
   assign step_tick = step_tick_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with N_LED=4, TICK_DIV=4, PWM_BITS=4.
// Also covers the brightness PWM when built with LED_PWM_EN.
module tb_led_pattern_ctrl;

   localparam int unsigned N_LED    = 4;
   localparam int unsigned TICK_DIV = 4;
   localparam int unsigned PWM_BITS = 4;

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic       ev_valid = 1'b0;
   logic       ev_read;
   logic       step_tick;
   logic [1:0] mode;
   logic [3:0] led;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef LED_PWM_EN
   logic [3:0] bright = 4'hF;
   logic [3:0] pc_m;
   logic       gate_m;

   // Reference PWM phase: gate_m says whether the LED register was enabled on the last edge.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_m   <= 4'd0;
         gate_m <= 1'b0;
      end else begin
         gate_m <= (pc_m < bright);
         pc_m   <= pc_m + 4'd1;
      end
   end
`endif

   led_pattern_ctrl #(
      .N_LED    (N_LED),
      .TICK_DIV (TICK_DIV),
      .PWM_BITS (PWM_BITS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ev_valid  (ev_valid),
`ifdef LED_PWM_EN
      .bright    (bright),
`endif
      .ev_read   (ev_read),
      .mode      (mode),
      .step_tick (step_tick),
      .led       (led)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] exp_led(input logic [3:0] p);
`ifdef LED_PWM_EN
      return p & {4{gate_m}};
`else
      return p;
`endif
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse();
      ev_valid = 1'b1;
      cyc(1);
      ev_valid = 1'b0;
   endtask

   task automatic test_reset();
      cyc(2);
      n_checks++;
      if ({mode, led, ev_read, step_tick} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_hold: got mode=%0d led=%b ev_read=%b step_tick=%b, want all 0",
                  mode, led, ev_read, step_tick);
      end
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc(1);
         n_checks++;
         if (led !== 4'b0000 || mode !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_idle[%0d]: got led=%b mode=%0d, want 0000/0", i, led, mode);
         end
      end
   endtask

   task automatic test_blink();
      logic [3:0] seq [3] = '{4'b1111, 4'b0000, 4'b1111};
      pulse();
      n_checks++;
      if (ev_read !== 1'b1 || mode !== 2'd1) begin
         n_fail++;
         $display("FAIL blink_accept: got ev_read=%b mode=%0d, want 1/1", ev_read, mode);
      end
      cyc(1);
      n_checks++;
      if (ev_read !== 1'b0) begin
         n_fail++;
         $display("FAIL blink_ev_read_drop: got %b want 0", ev_read);
      end
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (led !== exp_led(seq[k]) || step_tick !== (j == 3) || mode !== 2'd1) begin
               n_fail++;
               $display("FAIL blink_seq[%0d.%0d]: got led=%b tick=%b mode=%0d, want led=%b tick=%b mode=1",
                        k, j, led, step_tick, mode, exp_led(seq[k]), (j == 3));
            end
            cyc(1);
         end
      end
   endtask

   task automatic test_run();
      logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      pulse();
      n_checks++;
      if (ev_read !== 1'b1 || mode !== 2'd2) begin
         n_fail++;
         $display("FAIL run_accept: got ev_read=%b mode=%0d, want 1/2", ev_read, mode);
      end
      cyc(1);
      for (int k = 0; k < 5; k++) begin
         for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (led !== exp_led(seq[k]) || step_tick !== (j == 3)) begin
               n_fail++;
               $display("FAIL run_seq[%0d.%0d]: got led=%b tick=%b, want led=%b tick=%b",
                        k, j, led, step_tick, exp_led(seq[k]), (j == 3));
            end
            cyc(1);
         end
      end
   endtask

   task automatic test_fill();
      logic [3:0] seq [6] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000};
      pulse();
      n_checks++;
      if (mode !== 2'd3) begin
         n_fail++;
         $display("FAIL fill_mode: got %0d want 3", mode);
      end
      cyc(1);
      for (int k = 0; k < 6; k++) begin
         for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (led !== exp_led(seq[k])) begin
               n_fail++;
               $display("FAIL fill_seq[%0d.%0d]: got led=%b want %b", k, j, led, exp_led(seq[k]));
            end
            cyc(1);
         end
      end
      pulse();
      n_checks++;
      if (mode !== 2'd0 || ev_read !== 1'b1) begin
         n_fail++;
         $display("FAIL off_wrap_mode: got mode=%0d ev_read=%b, want 0/1", mode, ev_read);
      end
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         n_checks++;
         if (led !== 4'b0000) begin
            n_fail++;
            $display("FAIL off_led[%0d]: got %b want 0000", i, led);
         end
      end
   endtask

   task automatic test_event_at_wrap();
      pulse();
      cyc(2);
      pulse();
      cyc(7);
      n_checks++;
      if (led !== exp_led(4'b0010) || mode !== 2'd2 || step_tick !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_pre: got led=%b mode=%0d tick=%b, want %b/2/0",
                  led, mode, step_tick, exp_led(4'b0010));
      end
      pulse();
      n_checks++;
      if (mode !== 2'd3 || step_tick !== 1'b1 || ev_read !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_event: got mode=%0d tick=%b ev_read=%b, want 3/1/1",
                  mode, step_tick, ev_read);
      end
      cyc(1);
      n_checks++;
      if (led !== 4'b0000) begin
         n_fail++;
         $display("FAIL wrap_no_rotate: got led=%b want 0000", led);
      end
      cyc(2);
      n_checks++;
      if (step_tick !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_cnt_clear_tick: got %b want 0", step_tick);
      end
      cyc(1);
      n_checks++;
      if (step_tick !== 1'b1 || led !== 4'b0000) begin
         n_fail++;
         $display("FAIL wrap_first_step: got tick=%b led=%b, want 1/0000", step_tick, led);
      end
      cyc(1);
      n_checks++;
      if (led !== exp_led(4'b0001)) begin
         n_fail++;
         $display("FAIL wrap_first_fill: got led=%b want %b", led, exp_led(4'b0001));
      end
   endtask

   task automatic test_reset_mid_fill();
      cyc(4);
      n_checks++;
      if (mode !== 2'd3 || led !== exp_led(4'b0011)) begin
         n_fail++;
         $display("FAIL midfill_pre: got mode=%0d led=%b, want 3/%b", mode, led, exp_led(4'b0011));
      end
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if ({mode, led, ev_read, step_tick} !== 8'h00) begin
         n_fail++;
         $display("FAIL midfill_async_reset: got mode=%0d led=%b ev_read=%b tick=%b, want all 0",
                  mode, led, ev_read, step_tick);
      end
      cyc(1);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         n_checks++;
         if (led !== 4'b0000 || mode !== 2'd0) begin
            n_fail++;
            $display("FAIL midfill_after[%0d]: got led=%b mode=%0d, want 0000/0", i, led, mode);
         end
      end
   endtask

`ifdef LED_PWM_EN
   task automatic test_pwm();
      int on_cnt;
      int lit_cnt;
      pulse();
      cyc(2);
      pulse();
      bright = 4'd8;
      cyc(2);
      on_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (led !== 4'b0000) on_cnt++;
         cyc(1);
      end
      n_checks++;
      if (on_cnt !== 8) begin
         n_fail++;
         $display("FAIL pwm_half_duty: got %0d lit cycles of 16, want 8", on_cnt);
      end
      bright = 4'd0;
      cyc(1);
      lit_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (led !== 4'b0000) lit_cnt++;
         cyc(1);
      end
      n_checks++;
      if (lit_cnt !== 0) begin
         n_fail++;
         $display("FAIL pwm_dark: got %0d lit cycles of 16, want 0", lit_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_blink();
      test_run();
      test_fill();
      test_event_at_wrap();
      test_reset_mid_fill();
`ifdef LED_PWM_EN
      test_pwm();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
